// File: rtl/gb_bus_pkg.sv
// Shared Game Boy bus definitions: DMA FSM states, read-back source select,
// default register/OAM addresses and the open-bus value.
package gb_bus_pkg;

   typedef enum logic [1:0] {IDLE, SETUP, READ, WRITE} dma_state_t;

   // Source of the cpu_rdata value one cycle after the address was presented
   typedef enum logic [1:0] {RSEL_MEM, RSEL_SRC, RSEL_OPEN} rd_sel_t;

   localparam logic [15:0] DMA_REG_DEFAULT  = 16'hFF46;
   localparam logic [15:0] OAM_BASE_DEFAULT = 16'hFE00;
   localparam int          DMA_LEN_DEFAULT  = 160;
   localparam logic [7:0]  OPEN_BUS         = 8'hFF;

   // Pages E0-FF are an echo of C0-DF
   function automatic logic [7:0] echo_map(input logic [7:0] page);
      return (page >= 8'hE0) ? page - 8'h20 : page;
   endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine sharing one memory port with the CPU: idle passes the CPU through
// combinationally; a transfer copies DMA_LEN bytes in 1+2*DMA_LEN cycles, CPU locked out.
module oam_dma_arbiter
   import gb_bus_pkg::*;
#(
   parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
   parameter logic [15:0] OAM_BASE = OAM_BASE_DEFAULT,
   parameter int          DMA_LEN  = DMA_LEN_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_wren,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_wren,
   input  logic [7:0]  mem_rdata,
   output logic        dma_active
);

   localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

   dma_state_t state;
   rd_sel_t    rd_sel;
   logic [7:0] idx;
   logic [7:0] src_hi;
   logic [7:0] src_eff;
   logic       dma_reg_hit;
   logic       dma_reg_wr;

   assign dma_reg_hit = (cpu_addr == DMA_REG);
   assign dma_reg_wr  = cpu_wren && dma_reg_hit;
   assign src_eff     = echo_map(src_hi);
   assign dma_active  = (state != IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         idx    <= 8'h00;
         src_hi <= 8'h00;
         rd_sel <= RSEL_MEM;
      end else begin
         if (dma_reg_hit)
            rd_sel <= RSEL_SRC;
         else if (state != IDLE)
            rd_sel <= RSEL_OPEN;
         else
            rd_sel <= RSEL_MEM;

         // A DMA_REG write (re)starts a transfer from any state
         if (dma_reg_wr) begin
            src_hi <= cpu_wdata;
            idx    <= 8'h00;
            state  <= SETUP;
         end else begin
            case (state)
               IDLE:  state <= IDLE;
               SETUP: state <= READ;
               READ:  state <= WRITE;
               WRITE: begin
                  if (idx == LAST_IDX) begin
                     state <= IDLE;
                  end else begin
                     idx   <= idx + 8'd1;
                     state <= READ;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wren  = 1'b0;
      case (state)
         IDLE:  mem_wren = cpu_wren;
         SETUP: mem_addr = {src_eff, idx};
         READ:  mem_addr = {src_eff, idx};
         WRITE: begin
            mem_addr  = OAM_BASE + {8'h00, idx};
            mem_wdata = mem_rdata;
            mem_wren  = 1'b1;
         end
         default: mem_wren = 1'b0;
      endcase
   end

   always_comb begin
      case (rd_sel)
         RSEL_SRC:  cpu_rdata = src_hi;
         RSEL_OPEN: cpu_rdata = OPEN_BUS;
         default:   cpu_rdata = mem_rdata;
      endcase
   end

endmodule
